fifo_wptr_full: RTL and testbench

- Write-domain pointer and status stage of the async FIFO.
- Consumes the read pointer (Gray coded) after it has crossed into the write clock domain through per-bit N-stage synchronizers.
- Maintains the write pointer and produces the memory write strobe/address, plus the Gray write pointer handed to the read-side synchronizers.
- Generates full, almost-full, fill level and a sticky overflow flag.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_wptr_full.sv | 91 +++++++++
 tb/tb_fifo_wptr_full.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared Gray/binary pointer helpers for the async FIFO write- and read-side stages.
// Callers zero-extend narrower pointers to PTR_MAX_W and truncate the result back.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Leading zeros from zero-extension leave the prefix XOR unchanged.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
    logic [PTR_MAX_W-1:0] bin;
    bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/status stage of the async FIFO: write pointer, Gray pointer for
// the read-side synchronizers, and registered full / almost-full / level / overflow.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W:0]   i_rptr_gray_sync,
  input  logic              i_clr_overflow,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [ADDR_W:0]   o_wptr_gray,
  output logic              o_full,
  output logic              o_afull,
  output logic [ADDR_W:0]   o_wr_level,
  output logic              o_overflow
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] wbin_reg;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_reg;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_gray;
  logic [PW-1:0] level_reg;
  logic [PW-1:0] level_next;
  logic          full_reg;
  logic          full_next;
  logic          afull_reg;
  logic          afull_next;
  logic          overflow_reg;
  logic          overflow_next;

  assign o_mem_we = i_wr_en & ~full_reg;

  // Write pointer advance and read-pointer observation are folded into one next state,
  // so a simultaneous write and read-side free both land on the same edge.
  always_comb begin
    wbin_next  = wbin_reg + PW'(o_mem_we);
    wgray_next = PW'(bin2gray(PTR_MAX_W'(wbin_next)));
    rbin       = PW'(gray2bin(PTR_MAX_W'(i_rptr_gray_sync)));
    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    full_gray  = {~i_rptr_gray_sync[PW-1:PW-2], i_rptr_gray_sync[PW-3:0]};
    full_next  = (wgray_next == full_gray);
    level_next = wbin_next - rbin;
    afull_next = (level_next >= PW'(AFULL_THRESH));
  end

  // A write attempted while full takes priority over a same-cycle clear.
  always_comb begin
    overflow_next = overflow_reg;
    if (i_wr_en && full_reg) begin
      overflow_next = 1'b1;
    end else if (i_clr_overflow) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_reg     <= '0;
      wgray_reg    <= '0;
      full_reg     <= 1'b0;
      afull_reg    <= 1'b0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wbin_reg     <= wbin_next;
      wgray_reg    <= wgray_next;
      full_reg     <= full_next;
      afull_reg    <= afull_next;
      level_reg    <= level_next;
      overflow_reg <= overflow_next;
    end
  end

  // The Gray pointer leaves straight from a flop so the crossing sees glitch-free bits.
  assign o_wr_addr   = wbin_reg[ADDR_W-1:0];
  assign o_wptr_gray = wgray_reg;
  assign o_full      = full_reg;
  assign o_afull     = afull_reg;
  assign o_wr_level  = level_reg;
  assign o_overflow  = overflow_reg;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full: scenario tasks plus a count-based reference model.
module tb_fifo_wptr_full;

  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 16;
  localparam int MODV  = 32;
  localparam int THR   = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [PW-1:0] i_rptr_gray_sync = '0;
  logic          i_clr_overflow = 1'b0;
  logic          o_mem_we;
  logic [AW-1:0] o_wr_addr;
  logic [PW-1:0] o_wptr_gray;
  logic          o_full;
  logic          o_afull;
  logic [PW-1:0] o_wr_level;
  logic          o_overflow;

  fifo_wptr_full #(.ADDR_W(AW), .AFULL_THRESH(THR)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_wr_en          (i_wr_en),
    .i_rptr_gray_sync (i_rptr_gray_sync),
    .i_clr_overflow   (i_clr_overflow),
    .o_mem_we         (o_mem_we),
    .o_wr_addr        (o_wr_addr),
    .o_wptr_gray      (o_wptr_gray),
    .o_full           (o_full),
    .o_afull          (o_afull),
    .o_wr_level       (o_wr_level),
    .o_overflow       (o_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: total accepted writes as a plain count; everything else derived.
  int            m_wcount = 0;
  bit            m_full = 0;
  bit            m_ovf = 0;
  int            mem_we_seen = 0;
  bit            full_seen = 0;
  logic [PW-1:0] prev_gray = '0;

  function automatic logic [PW-1:0] to_gray(input int v);
    logic [PW-1:0] b;
    b = PW'(v % MODV);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_wcount  = 0;
    m_full    = 0;
    m_ovf     = 0;
    prev_gray = '0;
  endtask

  // One clock: drive at posedge+1, check accept at negedge, check registers at posedge+1.
  task automatic cycle(input bit wr, input int rcount, input bit clr, input string tag);
    bit            exp_we;
    bit            old_full;
    bit            exp_afull;
    int            wb;
    int            lvl;
    logic [PW-1:0] exp_gray;
    i_wr_en          = wr;
    i_clr_overflow   = clr;
    i_rptr_gray_sync = to_gray(rcount);
    exp_we           = wr && !m_full;
    @(negedge clk);
    checks++;
    if (o_mem_we !== exp_we) begin
      errors++;
      $display("FAIL %s mem_we: got %b want %b", tag, o_mem_we, exp_we);
    end
    if (o_mem_we === 1'b1) mem_we_seen++;
    @(posedge clk);
    old_full  = m_full;
    m_wcount += int'(exp_we);
    wb        = m_wcount % MODV;
    lvl       = ((wb - (rcount % MODV)) % MODV + MODV) % MODV;
    m_full    = (lvl == DEPTH);
    exp_afull = (lvl >= THR);
    if (wr && old_full) m_ovf = 1;
    else if (clr) m_ovf = 0;
    exp_gray  = to_gray(wb);
    #1;
    checks += 7;
    if (o_wr_addr !== AW'(wb % DEPTH)) begin
      errors++; $display("FAIL %s wr_addr: got %0d want %0d", tag, o_wr_addr, wb % DEPTH);
    end
    if (o_wptr_gray !== exp_gray) begin
      errors++; $display("FAIL %s wptr_gray: got %b want %b", tag, o_wptr_gray, exp_gray);
    end
    if (o_full !== m_full) begin
      errors++; $display("FAIL %s full: got %b want %b", tag, o_full, m_full);
    end
    if (o_afull !== exp_afull) begin
      errors++; $display("FAIL %s afull: got %b want %b", tag, o_afull, exp_afull);
    end
    if (o_wr_level !== PW'(lvl)) begin
      errors++; $display("FAIL %s level: got %0d want %0d", tag, o_wr_level, lvl);
    end
    if (o_overflow !== m_ovf) begin
      errors++; $display("FAIL %s overflow: got %b want %b", tag, o_overflow, m_ovf);
    end
    if ($countones(prev_gray ^ o_wptr_gray) > 1) begin
      errors++; $display("FAIL %s gray_step: got %b after %b want <=1 bit change", tag, o_wptr_gray, prev_gray);
    end
    prev_gray = o_wptr_gray;
    if (o_full === 1'b1) full_seen = 1;
    $display("%s wr=%0b rptr=%0d clr=%0b we=%0b addr=%0d gray=%b lvl=%0d full=%0b afull=%0b ovf=%0b",
             tag, wr, rcount % MODV, clr, exp_we, o_wr_addr, o_wptr_gray, o_wr_level,
             o_full, o_afull, o_overflow);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({o_mem_we, o_wr_addr, o_wptr_gray, o_full, o_afull, o_wr_level, o_overflow} !== '0) begin
      errors++;
      $display("FAIL %s outputs: got we=%b addr=%0d gray=%b full=%b afull=%b lvl=%0d ovf=%b want all 0",
               tag, o_mem_we, o_wr_addr, o_wptr_gray, o_full, o_afull, o_wr_level, o_overflow);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; i_wr_en = 1'b0; i_clr_overflow = 1'b0; i_rptr_gray_sync = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    check_all_zero("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) cycle(1'b1, 0, 1'b0, "reset_prefill");
    // Mid-cycle assertion: outputs must clear without a clock edge.
    #1;
    i_wr_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_all_zero("reset_async");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (o_wr_addr !== '0 || o_wptr_gray !== '0) begin
      errors++;
      $display("FAIL reset_release: got addr=%0d gray=%b want 0/00000", o_wr_addr, o_wptr_gray);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    mem_we_seen = 0;
    for (int i = 0; i < 16; i++) cycle(1'b1, 0, 1'b0, "fill");
    checks += 2;
    if (mem_we_seen != 16) begin
      errors++; $display("FAIL fill_accepts: got %0d want 16", mem_we_seen);
    end
    if (o_full !== 1'b1 || o_wr_level !== 5'd16 || o_wptr_gray !== 5'b11000) begin
      errors++;
      $display("FAIL fill_final: got full=%b lvl=%0d gray=%b want 1/16/11000", o_full, o_wr_level, o_wptr_gray);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 0, 1'b0, "ovf_set");
    cycle(1'b0, 0, 1'b1, "ovf_clear");
    cycle(1'b1, 0, 1'b1, "ovf_set_wins");
    checks++;
    if (o_overflow !== 1'b1 || o_wr_addr !== 4'd0) begin
      errors++; $display("FAIL ovf_final: got ovf=%b addr=%0d want 1/0", o_overflow, o_wr_addr);
    end
  endtask

  task automatic test_free();
    cycle(1'b0, 1, 1'b0, "free");
    checks++;
    if (o_full !== 1'b0 || o_wr_level !== 5'd15 || o_afull !== 1'b1) begin
      errors++; $display("FAIL free_first: got full=%b lvl=%0d afull=%b want 0/15/1", o_full, o_wr_level, o_afull);
    end
    for (int r = 2; r <= 5; r++) cycle(1'b0, r, 1'b0, "free");
    checks++;
    if (o_afull !== 1'b0 || o_wr_level !== 5'd11) begin
      errors++; $display("FAIL free_afull_drop: got afull=%b lvl=%0d want 0/11", o_afull, o_wr_level);
    end
  endtask

  task automatic test_wrap();
    bit            saw_gray_wrap = 0;
    bit            saw_addr_wrap = 0;
    logic [PW-1:0] g_before;
    logic [AW-1:0] a_before;
    apply_reset();
    full_seen = 0;
    for (int i = 0; i < 40; i++) begin
      g_before = o_wptr_gray;
      a_before = o_wr_addr;
      cycle(1'b1, (m_wcount >= 2) ? m_wcount - 2 : 0, 1'b0, "wrap");
      if (g_before === 5'b10000 && o_wptr_gray === 5'b00000) saw_gray_wrap = 1;
      if (a_before === 4'd15 && o_wr_addr === 4'd0) saw_addr_wrap = 1;
    end
    cycle(1'b0, m_wcount - 2, 1'b0, "wrap_settle");
    checks += 4;
    if (full_seen) begin
      errors++; $display("FAIL wrap_full: got full asserted want never");
    end
    if (!saw_gray_wrap) begin
      errors++; $display("FAIL wrap_gray: got no 10000->00000 step want one");
    end
    if (!saw_addr_wrap) begin
      errors++; $display("FAIL wrap_addr: got no 15->0 step want one");
    end
    if (o_wr_level !== 5'd2) begin
      errors++; $display("FAIL wrap_level: got %0d want 2", o_wr_level);
    end
  endtask

  task automatic test_random();
    int rc;
    rc = m_wcount - 2;
    for (int i = 0; i < 100; i++) begin
      rc += $urandom_range(0, 2);
      if (rc > m_wcount) rc = m_wcount;
      cycle(1'($urandom_range(0, 1)), rc, ($urandom_range(0, 7) == 0), "random");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_free();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
